// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up in a final cycle before the done pulse.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [1:0]            state_dbg
);

  // Handshake: start is taken only in IDLE while done is low; busy is high from
  // the edge that accepts start until the done cycle; done is a one-cycle pulse
  // with Result valid alongside it, and Result then holds until the next done.

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [2:0]    op;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W-1:0]  acc_hi;
  logic [W-1:0]  acc_lo;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;

  logic          is_div;
  logic          signed_a;
  logic          signed_b;
  logic          sign_a_in;
  logic          sign_b_in;
  logic [W-1:0]  a_mag_in;
  logic [W-1:0]  b_mag_in;
  logic          div_zero;
  logic          div_ovf;
  logic [W-1:0]  special_result;

  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic          div_ge;
  logic [W-1:0]  div_diff;

  logic [2*W-1:0] prod_full;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   fix_result;

  assign state_dbg = state;

  // Input decode: signedness, magnitudes and the cases that skip the iteration.
  always_comb begin
    is_div         = funct3[2];
    signed_a       = 1'b0;
    signed_b       = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'b010:  signed_a = 1'b1;
      default: ;
    endcase
    sign_a_in      = signed_a & SrcA[W-1];
    sign_b_in      = signed_b & SrcB[W-1];
    a_mag_in       = sign_a_in ? -SrcA : SrcA;
    b_mag_in       = sign_b_in ? -SrcB : SrcB;
    div_zero       = is_div && (SrcB == '0);
    div_ovf        = is_div && !funct3[0] && (SrcA == MIN_NEG) && (SrcB == ALL_ONES);
    special_result = '0;
    if (div_zero)
      special_result = funct3[1] ? SrcA : ALL_ONES;
    else if (div_ovf)
      special_result = funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration step for each operation class.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? a_mag : '0)};
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    div_diff  = div_shift[W-1:0] - b_mag;
  end

  always_comb begin
    prod_full  = {acc_hi, acc_lo};
    prod_fix   = neg_q ? -prod_full : prod_full;
    quo_fix    = neg_q ? -acc_lo : acc_lo;
    rem_fix    = neg_r ? -acc_hi : acc_hi;
    fix_result = '0;
    case (op)
      3'b000:                 fix_result = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*W-1:W];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op     <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // done still high here means this is the done cycle: ignore start.
          if (start && !done) begin
            op    <= funct3;
            neg_q <= sign_a_in ^ sign_b_in;
            neg_r <= sign_a_in;
            busy  <= 1'b1;
            if (div_zero || div_ovf) begin
              Result <= special_result;
              state  <= DONE;
            end else begin
              a_mag  <= a_mag_in;
              b_mag  <= b_mag_in;
              acc_hi <= '0;
              acc_lo <= is_div ? a_mag_in : b_mag_in;
              cnt    <= CW'(W);
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (op[2]) begin
            acc_hi <= div_ge ? div_diff : div_shift[W-1:0];
            acc_lo <= {acc_lo[W-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[W:1];
            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= FIX;
        end
        FIX: begin
          Result <= fix_result;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in the execute stage. The datapath hands it two operands and a funct3 code with a start pulse, stalls on `busy`, and collects `Result` when `done` pulses. Multiply uses shift-add and divide uses restoring division, one bit per cycle.

## Interface
- `DATA_WIDTH`, 32, operand/result width; iteration count equals `DATA_WIDTH`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA`  in  DATA_WIDTH  rs1 operand (multiplicand/dividend); sampled with `start`.
- `SrcB`  in  DATA_WIDTH  rs2 operand (multiplier/divisor); sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance until `done` has pulsed.
- `done`  out  1  one-cycle pulse; `Result` is valid in the same cycle.
- `Result`  out  DATA_WIDTH  registered result; holds its value until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `start`=1 latches `SrcA`, `SrcB` and `funct3`, and records the operand signs.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - Operands are converted to magnitudes, the iteration counter is loaded with `DATA_WIDTH`, and the state moves to CALC.
- Special cases, detected in IDLE, go directly to DONE with no CALC or FIX:
  - Divide by zero (B=0): DIV/DIVU → all-ones; REM/REMU → A.
  - Signed overflow (DIV/REM, A=0x8000_0000, B=0xFFFF_FFFF): DIV → 0x8000_0000; REM → 0.
- CALC, multiply: 2·DATA_WIDTH-bit product register; one shift-add step per cycle.
- CALC, divide: restoring step per cycle over the remainder:quotient register pair.
- CALC ends when the counter reaches 0, then the state moves to FIX.
- FIX: applies sign correction (two's-complement negate where needed) and selects the output:
  - MUL → product[31:0]; MULH/MULHSU/MULHU → product[63:32].
  - Quotient sign = signA XOR signB.
  - Remainder sign = sign of the dividend.
  - Writes `Result`, then the state moves to DONE.
- DONE: `done`=1 for exactly one cycle, `busy` drops in that same cycle, and the state returns to IDLE.
- `start` asserted while not in IDLE is ignored; no queuing.
- `start` asserted in the DONE cycle is ignored. The earliest back-to-back start is the cycle after `done`.

## Timing
- Start accepted at edge E0:
  - `busy`=1 from E0.
  - Normal ops: `done`=1 during the cycle following edge E0+34 (CALC 32 + FIX 1 + DONE 1 cycles).
  - Special cases: `done`=1 during the cycle following edge E0+1.
- `busy` falls together with `done` (i.e. `busy`=0 in the DONE cycle).
- Reset values: state IDLE, `busy`=0, `done`=0, `Result`=0, internal registers 0.
- Reset asserted mid-operation aborts on that edge: no `done` pulse and `Result`=0. A new `start` is accepted on the first edge after `reset` deasserts.
- Operand inputs may change freely after acceptance; only the latched copies are used.

## Test plan
- MUL 7 × −3 (0x0000_0007, 0xFFFF_FFFD) → `done` at E0+34, `Result`=0xFFFF_FFEB. MULH with the same operands → 0xFFFF_FFFF. MULHU with the same operands → 0x0000_0006.
- DIV −20 / 3 → 0xFFFF_FFFA. REM −20 / 3 → 0xFFFF_FFFE. DIVU 0xFFFF_FFEC / 3 → 0x5555_554E.
- DIV by zero (A=0x1234, B=0) → `done` at E0+1, `Result`=0xFFFF_FFFF. REMU by zero with the same A → 0x0000_1234.
- DIV 0x8000_0000 / 0xFFFF_FFFF → `done` at E0+1, `Result`=0x8000_0000. REM with the same operands → 0.
- `start` re-pulsed at E0+10 with different operands → ignored; the first result is delivered unchanged at E0+34. A new start in the cycle after `done` is accepted.
- `reset` at E0+15 of a MULHU → `busy`=0, `done` never pulses, `Result`=0. A subsequent MULHSU 0xFFFF_FFFF × 2 → 0xFFFF_FFFF.
